// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, default frame
// marker and the instruction width used by the memory and the CPU.
package program_loader_pkg;

  localparam int         INSTR_W           = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    LEN,
    HI,
    LO,
    CHECK,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/N/payload[/checksum] byte frames, writes 16-bit words
// to instruction memory and holds the CPU in reset until an image is accepted.
// Define PROGRAM_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = INSTR_W,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  // One extra bit so that N=0 can stand for a full 2^ADDR_W-word image.
  localparam int CNT_W = ADDR_W + 1;

  state_e              state_q;
  logic                s_ready_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic                cpu_reset_q;
  logic                load_done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          hi_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]          acc_q;
  logic                load_error_q;
`endif

  logic accept;
  logic is_sync;

  assign accept  = s_valid && s_ready_q;
  assign is_sync = (s_data == SYNC_BYTE);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values; a later assignment to the same
  // register in this block overrides an earlier default.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q      <= SYNC;
      s_ready_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc_q        <= '0;
      load_error_q <= 1'b0;
`endif
    end else begin
      s_ready_q <= 1'b1;
      mem_wr_q  <= 1'b0;
      case (state_q)
        SYNC: begin
          if (accept && is_sync) begin
            state_q     <= LEN;
            cpu_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            load_error_q <= 1'b0;
`endif
          end
        end
        LEN: begin
          if (accept) begin
            cnt_q   <= (s_data == 8'h00) ? (CNT_W'(1) << ADDR_W) : CNT_W'(s_data);
            addr_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
            state_q <= HI;
          end
        end
        HI: begin
          if (accept) begin
            hi_q    <= s_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q   <= acc_q ^ s_data;
`endif
            state_q <= LO;
          end
        end
        LO: begin
          if (accept) begin
            mem_wr_q   <= 1'b1;
            mem_din_q  <= {hi_q, s_data};
            mem_addr_q <= addr_q;
            addr_q     <= addr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q      <= acc_q ^ s_data;
`endif
            if (cnt_q == CNT_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q     <= CHECK;
`else
              state_q     <= DONE;
              load_done_q <= 1'b1;
`endif
            end else begin
              state_q <= HI;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (s_data == acc_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= ERROR;
              load_error_q <= 1'b1;
              cpu_reset_q  <= 1'b1;
            end
          end
        end
        ERROR: begin
          if (accept && is_sync) begin
            state_q      <= LEN;
            load_error_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
          end
        end
`endif
        DONE: begin
          // CPU is released one edge after entry unless a reload starts first.
          if (accept && is_sync) begin
            state_q     <= LEN;
            load_done_q <= 1'b0;
            cpu_reset_q <= 1'b1;
          end else begin
            cpu_reset_q <= 1'b0;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign mem_wr      = mem_wr_q;
  assign mem_address = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign cpu_reset   = cpu_reset_q;
  assign load_done   = load_done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_error  = load_error_q;
`else
  assign load_error  = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; follows the DUT build
// (PROGRAM_LOADER_CHECKSUM_EN decides whether a checksum byte is sent).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        mem_wr;
  logic [7:0]  mem_address;
  logic [15:0] mem_din;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  program_loader dut (
    .clk        (clk),
    .areset     (areset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_wr     (mem_wr),
    .mem_address(mem_address),
    .mem_din    (mem_din),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_din);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte after 'gap' idle cycles; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Basic frame without the leading sync byte: N=2, 1234, 5678, optional checksum.
  task automatic send_body(input int gap_max, input logic [7:0] ck);
    logic [7:0] f [5];
    f = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 5; i++) send_byte(f[i], int'($urandom_range(0, gap_max)));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(ck, int'($urandom_range(0, gap_max)));
`endif
  endtask

  task automatic send_basic(input int gap_max, input logic [7:0] ck);
    send_byte(8'hA5, int'($urandom_range(0, gap_max)));
    send_body(gap_max, ck);
  endtask

  task automatic reset_pulse;
    areset  = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b0;
    #12;
    checks++;
    if ({s_ready, mem_wr, mem_address, mem_din, cpu_reset, load_done, load_error} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b wr=%b addr=%h din=%h cpu_rst=%b done=%b err=%b, want 0 0 00 0000 1 0 0",
               s_ready, mem_wr, mem_address, mem_din, cpu_reset, load_done, load_error);
    end
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic test_basic_load;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    checks++;
    if (mem_wr !== 1'b0) begin
      failures++;
      $display("FAIL no_write_on_hi: mem_wr=%b want 0", mem_wr);
    end
    send_byte(8'h34, 0);
    checks++;
    if ({mem_wr, mem_address, mem_din} !== {1'b1, 8'h00, 16'h1234}) begin
      failures++;
      $display("FAIL write0_latency: wr=%b addr=%h din=%h want 1 00 1234", mem_wr, mem_address, mem_din);
    end
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    checks++;
    if ({mem_wr, mem_address, mem_din} !== {1'b1, 8'h01, 16'h5678}) begin
      failures++;
      $display("FAIL write1_latency: wr=%b addr=%h din=%h want 1 01 5678", mem_wr, mem_address, mem_din);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checks++;
    if ({load_done, cpu_reset} !== 2'b01) begin
      failures++;
      $display("FAIL pre_checksum: done=%b cpu_rst=%b want 0 1", load_done, cpu_reset);
    end
    send_byte(8'h08, 0);
`endif
    checks++;
    if ({load_done, cpu_reset, load_error} !== 3'b110) begin
      failures++;
      $display("FAIL done_entry: done=%b cpu_rst=%b err=%b want 1 1 0", load_done, cpu_reset, load_error);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({load_done, cpu_reset} !== 2'b10) begin
      failures++;
      $display("FAIL cpu_release: done=%b cpu_rst=%b want 1 0", load_done, cpu_reset);
    end
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++;
      $display("FAIL basic_write_count: got %0d want 2", wr_addr_q.size());
    end
  endtask

  task automatic test_bad_checksum;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    wr_addr_q.delete();
    wr_data_q.delete();
    send_basic(0, 8'h09);
    @(posedge clk);
    #1;
    checks++;
    if ({load_error, cpu_reset, load_done} !== 3'b110) begin
      failures++;
      $display("FAIL bad_checksum: err=%b cpu_rst=%b done=%b want 1 1 0", load_error, cpu_reset, load_done);
    end
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++;
      $display("FAIL bad_frame_writes_kept: got %0d want 2", wr_addr_q.size());
    end
    send_byte(8'hA5, 0);
    checks++;
    if ({load_error, cpu_reset} !== 2'b01) begin
      failures++;
      $display("FAIL error_cleared: err=%b cpu_rst=%b want 0 1", load_error, cpu_reset);
    end
    send_body(0, 8'h08);
    @(posedge clk);
    #1;
    checks++;
    if ({load_done, cpu_reset, load_error} !== 3'b100) begin
      failures++;
      $display("FAIL recover_after_error: done=%b cpu_rst=%b err=%b want 1 0 0", load_done, cpu_reset, load_error);
    end
`endif
  endtask

  task automatic test_junk_before_sync;
    reset_pulse();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 0);
    @(posedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() != 0 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL junk_ignored: writes=%0d cpu_rst=%b done=%b want 0 1 0", wr_addr_q.size(), cpu_reset, load_done);
    end
    send_basic(0, 8'h08);
    @(posedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 16'h1234 ||
        wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 16'h5678 || load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL junk_then_frame: addrs=%p data=%p done=%b cpu_rst=%b want '{0,1} '{1234,5678} 1 0",
               wr_addr_q, wr_data_q, load_done, cpu_reset);
    end
  endtask

  task automatic test_full_load;
    logic [7:0] ck;
    int bad;
    int first_bad;
    ck = 8'h00;
    bad = 0;
    first_bad = -1;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 0);
      send_byte(8'(i), 0);
      ck = ck ^ 8'(i);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(ck, 0);
`endif
    @(posedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() != 256) begin
      failures++;
      $display("FAIL full_write_count: got %0d want 256", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 16'(i)) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL full_data: %0d bad words, first at %0d: addr=%h din=%h want %h %h",
                 bad, first_bad, wr_addr_q[first_bad], wr_data_q[first_bad], 8'(first_bad), 16'(first_bad));
      end
    end
    checks++;
    if ({load_done, cpu_reset, load_error} !== 3'b100) begin
      failures++;
      $display("FAIL full_done: done=%b cpu_rst=%b err=%b want 1 0 0", load_done, cpu_reset, load_error);
    end
  endtask

  task automatic test_reload_and_reset;
    send_byte(8'hA5, 0);
    checks++;
    if ({cpu_reset, load_done} !== 2'b10) begin
      failures++;
      $display("FAIL reload_reasserts: cpu_rst=%b done=%b want 1 0", cpu_reset, load_done);
    end
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    areset = 1'b0;
    #1;
    checks++;
    if ({s_ready, mem_wr, mem_address, mem_din, cpu_reset, load_done, load_error} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midframe_reset: rdy=%b wr=%b addr=%h din=%h cpu_rst=%b done=%b err=%b, want 0 0 00 0000 1 0 0",
               s_ready, mem_wr, mem_address, mem_din, cpu_reset, load_done, load_error);
    end
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #1;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_basic(0, 8'h08);
    @(posedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 16'h1234 ||
        wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 16'h5678 || load_done !== 1'b1 || cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL fresh_after_reset: addrs=%p data=%p done=%b cpu_rst=%b want '{0,1} '{1234,5678} 1 0",
               wr_addr_q, wr_data_q, load_done, cpu_reset);
    end
  endtask

  task automatic test_gapped_stream;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_basic(5, 8'h08);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 16'h1234 ||
        wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 16'h5678 || load_done !== 1'b1 ||
        cpu_reset !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL gapped_stream: addrs=%p data=%p done=%b cpu_rst=%b err=%b want '{0,1} '{1234,5678} 1 0 0",
               wr_addr_q, wr_data_q, load_done, cpu_reset, load_error);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_junk_before_sync();
    test_full_load();
    test_reload_and_reset();
    test_gapped_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
